// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller for the 8-bit ALU.
// Takes one instruction at a time and reads operands from a 4-entry register file.
// It drives the ALU inputs, captures the result and PSW, then writes them back.
// dbg_data gives a combinational view of any register.
module alu_exec_ctrl #(
  parameter int DATA_W = 8,
  parameter int PSW_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [PSW_W-1:0]  alu_psw,
  output logic              done,
  output logic [PSW_W-1:0]  flags,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_t;

  state_t              state;
  logic [15:0]         instr_q;
  logic [DATA_W-1:0]   res_q;
  logic [PSW_W-1:0]    psw_q;
  logic [DATA_W-1:0]   regs [4];

  // Instruction field decode from the latched instruction
  logic [2:0] op;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;
  logic       imm_en;
  logic [7:0] imm;

  assign op     = instr_q[15:13];
  assign rd     = instr_q[12:11];
  assign rs1    = instr_q[10:9];
  assign imm_en = instr_q[8];
  assign imm    = instr_q[7:0];
  assign rs2    = instr_q[1:0];

  // Debug read port; shows the pre-write value during WB
  assign dbg_data = regs[dbg_addr];

  // Sequencer: IDLE -> READ -> EXEC -> WB, all outputs registered.
  // alu_a/alu_b double as the operand latches, so they hold outside EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      in_ready <= 1'b1;
      done     <= 1'b0;
      flags    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      instr_q  <= '0;
      res_q    <= '0;
      psw_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (in_valid) begin
            instr_q  <= in_instr;
            in_ready <= 1'b0;
            state    <= StRead;
          end
        end
        StRead: begin
          alu_a   <= regs[rs1];
          alu_b   <= imm_en ? DATA_W'(imm) : regs[rs2];
          alu_sel <= op;
          state   <= StExec;
        end
        StExec: begin
          res_q <= alu_result;
          psw_q <= alu_psw;
          done  <= 1'b1;
          state <= StWb;
        end
        StWb: begin
          regs[rd] <= res_q;
          flags    <= psw_q;
          in_ready <= 1'b1;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
